// File: rtl/clusterv_tile_sram_pkg.sv
// Shared types and width helpers for the clusterv tile SRAM and its arbiter.
package clusterv_tile_sram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // ceil(log2(v)); 0 for v <= 1
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // index width that stays at least one bit wide for a single-entry range
  function automatic int idx_w(input int n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

  // byte lanes in a data word
  function automatic int lanes(input int dw);
    return dw / 8;
  endfunction

  // even parity bit for one byte: the stored 9 bits always XOR to 0
  function automatic logic byte_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/clusterv_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr+1,
// then moves ptr to the winner. ptr resets to N-1 so index 0 wins first.
module clusterv_rr_arbiter
  import clusterv_tile_sram_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N-1:0]        req_i,
  output logic [N-1:0]        gnt_o,
  output logic [idx_w(N)-1:0] gnt_idx_o,
  output logic                gnt_vld_o
);

  localparam int PW = idx_w(N);

  logic [PW-1:0] ptr_q, ptr_d;

  // rotating priority search starting one past the last winner
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = ptr_q;
    gnt_vld_o = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!gnt_vld_o && req_i[(int'(ptr_q) + k) % N]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = PW'((int'(ptr_q) + k) % N);
      end
    end
    if (gnt_vld_o) gnt_o[gnt_idx_o] = 1'b1;
    ptr_d = gnt_vld_o ? gnt_idx_o : ptr_q;
  end

  // pointer register, holds when nothing is granted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ptr_q <= PW'(N - 1);
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/clusterv_tile_sram_arb.sv
// Multi-initiator byte-enable tile SRAM: N_PORTS req/ack ports share one
// single-port array via round-robin arbitration. A clear pass runs after
// reset before any grant. Optional per-byte even parity is enabled by
// defining CLUSTERV_TILE_SRAM_ARB_PARITY_EN.
module clusterv_tile_sram_arb
  import clusterv_tile_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int N_PORTS    = 2
) (
  input  logic                                clock,
  input  logic                                reset,
  output logic                                init_done,
  input  logic [N_PORTS-1:0]                  t_req,
  output logic [N_PORTS-1:0]                  t_ack,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]       t_addr,
  input  logic [N_PORTS-1:0]                  t_write_en,
  input  logic [N_PORTS*(DATA_WIDTH/8)-1:0]   t_byte_en,
  input  logic [N_PORTS*DATA_WIDTH-1:0]       t_write_data,
  output logic [N_PORTS*DATA_WIDTH-1:0]       t_read_data,
  output logic [N_PORTS-1:0]                  t_read_valid,
  output logic [N_PORTS-1:0]                  t_parity_err
);

  localparam int NB    = lanes(DATA_WIDTH);
  localparam int WA    = clog2(NB);
  localparam int AW    = ADDR_WIDTH - WA;
  localparam int DEPTH = 2 ** AW;
  localparam int PW    = idx_w(N_PORTS);
`ifdef CLUSTERV_TILE_SRAM_ARB_PARITY_EN
  localparam int SW    = DATA_WIDTH + NB;
`else
  localparam int SW    = DATA_WIDTH;
`endif

  state_e                                  state_q, state_d;
  logic [AW-1:0]                           cnt_q, cnt_d;
  logic                                    ready;
  logic [PW-1:0]                           gnt_idx;
  logic                                    gnt_vld;
  logic                                    mem_en, mem_we;
  logic [AW-1:0]                           mem_addr;
  logic [NB-1:0]                           mem_be;
  logic [DATA_WIDTH-1:0]                   mem_wdata;
  logic [SW-1:0]                           mem_q [DEPTH];
  logic [SW-1:0]                           rd_q;
  logic [N_PORTS-1:0]                      rvld_q, rvld_d;
  logic [N_PORTS-1:0][DATA_WIDTH-1:0]      hold_q, hold_d;
  logic                                    par_bad;

  assign ready     = (state_q == ST_READY);
  assign init_done = ready;

  // clear-pass sequencing: one word per cycle, then normal service
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == AW'(DEPTH - 1)) state_d = ST_READY;
    end
  end

  // state and clear counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  clusterv_rr_arbiter #(.N(N_PORTS)) u_arb (
    .clock     (clock),
    .reset     (reset),
    .req_i     (t_req & {N_PORTS{ready}}),
    .gnt_o     (t_ack),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  // steer either the clear pass or the granted port onto the array
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = cnt_q;
    mem_be    = '1;
    mem_wdata = '0;
    if (!ready) begin
      mem_en = 1'b1;
      mem_we = 1'b1;
    end else if (gnt_vld) begin
      mem_en    = 1'b1;
      mem_we    = t_write_en[gnt_idx];
      mem_addr  = t_addr[int'(gnt_idx)*ADDR_WIDTH + WA +: AW];
      mem_be    = t_byte_en[int'(gnt_idx)*NB +: NB];
      mem_wdata = t_write_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // single-port storage; kept as one block so a macro can drop in here
  always_ff @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < NB; b++) begin
          if (mem_be[b]) begin
            mem_q[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
`ifdef CLUSTERV_TILE_SRAM_ARB_PARITY_EN
            mem_q[mem_addr][DATA_WIDTH + b] <= byte_par(mem_wdata[b*8 +: 8]);
`endif
          end
        end
      end else begin
        rd_q <= mem_q[mem_addr];
      end
    end
  end

  // read return: valid for one cycle after a read grant, data held after
  always_comb begin
    rvld_d = t_ack & ~t_write_en;
    hold_d = hold_q;
    for (int p = 0; p < N_PORTS; p++) begin
      if (rvld_q[p]) hold_d[p] = rd_q[DATA_WIDTH-1:0];
      t_read_data[p*DATA_WIDTH +: DATA_WIDTH] =
        rvld_q[p] ? rd_q[DATA_WIDTH-1:0] : hold_q[p];
    end
  end

  // read-return registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rvld_q <= '0;
      hold_q <= '0;
    end else begin
      rvld_q <= rvld_d;
      hold_q <= hold_d;
    end
  end

  assign t_read_valid = rvld_q;

  // parity check on the word just read
  always_comb begin
    par_bad = 1'b0;
`ifdef CLUSTERV_TILE_SRAM_ARB_PARITY_EN
    for (int b = 0; b < NB; b++)
      if (rd_q[DATA_WIDTH + b] != byte_par(rd_q[b*8 +: 8])) par_bad = 1'b1;
`endif
    t_parity_err = rvld_q & {N_PORTS{par_bad}};
  end

endmodule

// File: tb/tb_clusterv_tile_sram_arb.sv
// Directed bench for clusterv_tile_sram_arb: default 2-port instance plus a
// small 4-port instance for rotation order.
module tb_clusterv_tile_sram_arb;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // 2-port, 1 KiB instance
  logic [1:0]  a_req = '0, a_we = '0, a_ack, a_rv, a_pe;
  logic [19:0] a_addr = '0;
  logic [7:0]  a_be = '0;
  logic [63:0] a_wd = '0, a_rd;
  logic        a_done;

  // 4-port, 4-word instance
  logic [3:0]   b_req = '0, b_we = '0, b_ack, b_rv, b_pe;
  logic [15:0]  b_addr = '0;
  logic [15:0]  b_be = '0;
  logic [127:0] b_wd = '0, b_rd;
  logic         b_done;

  clusterv_tile_sram_arb #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .N_PORTS(2)) dut_a (
    .clock(clock), .reset(reset), .init_done(a_done),
    .t_req(a_req), .t_ack(a_ack), .t_addr(a_addr), .t_write_en(a_we),
    .t_byte_en(a_be), .t_write_data(a_wd), .t_read_data(a_rd),
    .t_read_valid(a_rv), .t_parity_err(a_pe));

  clusterv_tile_sram_arb #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .N_PORTS(4)) dut_b (
    .clock(clock), .reset(reset), .init_done(b_done),
    .t_req(b_req), .t_ack(b_ack), .t_addr(b_addr), .t_write_en(b_we),
    .t_byte_en(b_be), .t_write_data(b_wd), .t_read_data(b_rd),
    .t_read_valid(b_rv), .t_parity_err(b_pe));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic rq, input logic we, input logic [9:0] ad,
                          input logic [3:0] be, input logic [31:0] wd);
    a_req[p] = rq;
    a_we[p] = we;
    a_addr[p*10 +: 10] = ad;
    a_be[p*4 +: 4] = be;
    a_wd[p*32 +: 32] = wd;
  endtask

  // one isolated access on port p; returns what is seen the cycle after ack
  task automatic access(input int p, input logic we, input logic [9:0] ad, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd, output logic vld,
                        output logic pe);
    bit got;
    @(posedge clock); #1;
    set_port(p, 1'b1, we, ad, be, wd);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (a_ack[p]) got = 1'b1;
    end
    chk($sformatf("ack_wait_p%0d", p), 64'(got), 64'd1);
    @(posedge clock); #1;
    a_req[p] = 1'b0;
    @(negedge clock);
    rd  = a_rd[p*32 +: 32];
    vld = a_rv[p];
    pe  = a_pe[p];
  endtask

  // release reset and count cycles with init_done low; acks seen while low
  task automatic count_init(output int cyc, output int acks);
    cyc = 0;
    acks = 0;
    while (cyc < 2000) begin
      @(negedge clock);
      if (a_done) break;
      cyc++;
      if (a_ack != 2'b00) acks++;
    end
  endtask

  typedef struct {
    int          p;
    logic        we;
    logic [9:0]  ad;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tv[12];

  initial begin
    logic [31:0] rd;
    logic vld, pe;
    int cyc, acks;
    logic [31:0] exp_d;
    logic exp_pe;

    tv[0]  = '{0, 1'b0, 10'h000, 4'h0, 32'h0,        32'h0};
    tv[1]  = '{1, 1'b0, 10'h3FC, 4'h0, 32'h0,        32'h0};
    tv[2]  = '{0, 1'b1, 10'h010, 4'hF, 32'hDEADBEEF, 32'h0};
    tv[3]  = '{0, 1'b1, 10'h010, 4'h1, 32'h000000AA, 32'h0};
    tv[4]  = '{0, 1'b0, 10'h010, 4'h0, 32'h0,        32'hDEADBEAA};
    tv[5]  = '{1, 1'b1, 10'h020, 4'hF, 32'h12345678, 32'h0};
    tv[6]  = '{0, 1'b0, 10'h020, 4'h0, 32'h0,        32'h12345678};
    tv[7]  = '{1, 1'b1, 10'h013, 4'h4, 32'h00550000, 32'h0};
    tv[8]  = '{1, 1'b0, 10'h011, 4'h0, 32'h0,        32'hDE55BEAA};
    tv[9]  = '{0, 1'b1, 10'h030, 4'h0, 32'hFFFFFFFF, 32'h0};
    tv[10] = '{0, 1'b0, 10'h030, 4'h0, 32'h0,        32'h0};
    tv[11] = '{1, 1'b0, 10'h010, 4'h0, 32'h0,        32'hDE55BEAA};

    // reset values
    @(posedge clock); @(negedge clock);
    chk("rst_init_done", 64'(a_done), 64'd0);
    chk("rst_ack", 64'(a_ack), 64'd0);
    chk("rst_rvalid", 64'(a_rv), 64'd0);
    chk("rst_perr", 64'(a_pe), 64'd0);
    chk("rst_rdata", a_rd, 64'd0);

    // clear pass with both ports requesting reads the whole time
    a_req = 2'b11;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    count_init(cyc, acks);
    a_req = 2'b00;
    chk("init_cycles", 64'(cyc), 64'd256);
    chk("init_no_ack", 64'(acks), 64'd0);

    // 4-port rotation: 0,1,2,3,0
    chk("b_init_done", 64'(b_done), 64'd1);
    @(posedge clock); #1;
    b_req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk($sformatf("b_rr_%0d", i), 64'(b_ack), 64'(4'b0001 << (i % 4)));
      if (i == 1) begin
        chk("b_rvalid", 64'(b_rv), 64'h1);
        chk("b_rdata0", 64'(b_rd[31:0]), 64'h0);
        chk("b_perr", 64'(b_pe), 64'h0);
      end
      @(posedge clock); #1;
    end
    b_req = 4'h0;

    // table of isolated accesses
    for (int i = 0; i < 12; i++) begin
      access(tv[i].p, tv[i].we, tv[i].ad, tv[i].be, tv[i].wd, rd, vld, pe);
      chk($sformatf("tv%0d_valid", i), 64'(vld), 64'(!tv[i].we));
      if (!tv[i].we) begin
        chk($sformatf("tv%0d_rdata", i), 64'(rd), 64'(tv[i].exp_rd));
        chk($sformatf("tv%0d_perr", i), 64'(pe), 64'd0);
      end
    end

    // both ports requesting: last grant was port 1, so 0,1,0,1
    @(posedge clock); #1;
    set_port(0, 1'b1, 1'b0, 10'h010, 4'h0, 32'h0);
    set_port(1, 1'b1, 1'b0, 10'h020, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk($sformatf("rr2_%0d", i), 64'(a_ack), (i % 2 == 0) ? 64'h1 : 64'h2);
    end
    @(posedge clock); #1;
    a_req = 2'b00;

    // back-to-back reads on one port give consecutive valid pulses
    @(posedge clock); #1;
    set_port(0, 1'b1, 1'b0, 10'h010, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      if (i == 2) a_req[0] = 1'b0;
      @(negedge clock);
      chk($sformatf("b2b_valid_%0d", i), 64'(a_rv[0]), 64'd1);
    end
    @(negedge clock);
    chk("b2b_valid_end", 64'(a_rv[0]), 64'd0);
    chk("b2b_rdata_held", 64'(a_rd[31:0]), 64'hDE55BEAA);

    // write from port 1 then read on port 0 on the very next grant
    @(posedge clock); #1;
    set_port(1, 1'b1, 1'b1, 10'h040, 4'hF, 32'hCAFEF00D);
    set_port(0, 1'b1, 1'b0, 10'h040, 4'h0, 32'h0);
    @(negedge clock);
    chk("raw_ack_wr", 64'(a_ack), 64'h2);
    @(posedge clock); #1;
    a_req[1] = 1'b0;
    @(negedge clock);
    chk("raw_ack_rd", 64'(a_ack), 64'h1);
    @(posedge clock); #1;
    a_req[0] = 1'b0;
    @(negedge clock);
    chk("raw_valid", 64'(a_rv), 64'h1);
    chk("raw_rdata", 64'(a_rd[31:0]), 64'hCAFEF00D);

    // parity: corrupt byte 2 of word 0x050 and read it back
    access(0, 1'b1, 10'h050, 4'hF, 32'h11223344, rd, vld, pe);
`ifdef CLUSTERV_TILE_SRAM_ARB_PARITY_EN
    dut_a.mem_q[20][16] = ~dut_a.mem_q[20][16];
    exp_d  = 32'h11233344;
    exp_pe = 1'b1;
`else
    exp_d  = 32'h11223344;
    exp_pe = 1'b0;
`endif
    access(0, 1'b0, 10'h050, 4'h0, 32'h0, rd, vld, pe);
    chk("par_valid", 64'(vld), 64'd1);
    chk("par_rdata", 64'(rd), 64'(exp_d));
    chk("par_perr", 64'(pe), 64'(exp_pe));
    @(negedge clock);
    chk("par_perr_pulse", 64'(a_pe), 64'd0);

    // reset mid-traffic while a read return is visible
    @(posedge clock); #1;
    set_port(0, 1'b1, 1'b0, 10'h010, 4'h0, 32'h0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("mt_valid_before", 64'(a_rv[0]), 64'd1);
    reset = 1'b1;
    #1;
    chk("mt_ack", 64'(a_ack), 64'd0);
    chk("mt_valid", 64'(a_rv), 64'd0);
    chk("mt_rdata", a_rd, 64'd0);
    chk("mt_done", 64'(a_done), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // reset again part-way through the clear pass; it restarts from 0
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (a_ack != 2'b00) chk("mid_init_ack", 64'(a_ack), 64'd0);
    end
    reset = 1'b1;
    #1;
    chk("mi_done", 64'(a_done), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    count_init(cyc, acks);
    a_req = 2'b00;
    chk("reinit_cycles", 64'(cyc), 64'd256);
    chk("reinit_no_ack", 64'(acks), 64'd0);

    // previously written words are cleared
    access(0, 1'b0, 10'h010, 4'h0, 32'h0, rd, vld, pe);
    chk("clr_010", 64'(rd), 64'd0);
    access(1, 1'b0, 10'h040, 4'h0, 32'h0, rd, vld, pe);
    chk("clr_040", 64'(rd), 64'd0);
    chk("clr_perr", 64'(pe), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // absolute time guard
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
